axi_a_arbiter: RTL and testbench
================================

AXI_A_ARBITER -- requirements
Module: axi_a_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `AXI_ADDR_WIDTH (32), address width.
REQ-002 SHALL have parameter ID_WIDTH, default `AXI_ID_WIDTH (4), transaction ID width.
REQ-003 SHALL have parameter ADDR_LEN, default 4, burst-length field width.
REQ-004 SHALL have parameter BATCH_LEN, default 4, range 1..15, maximum consecutive same-direction grants under contention.
REQ-005 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have write address channel inputs awvalid (1), awid (ID_WIDTH), awaddr (ADDR_WIDTH), awlen (ADDR_LEN), awsize (3), awburst (2), and output awready (1).
REQ-007 SHALL have read address channel inputs arvalid (1), arid (ID_WIDTH), araddr (ADDR_WIDTH), arlen (ADDR_LEN), arsize (3), arburst (2), and output arready (1).
REQ-008 SHALL have merged A-channel outputs avalid (1), aid, aaddr, alen, asize, aburst (widths as above), and awrite (1, 1 = write).
REQ-009 SHALL have merged A-channel input aready (1).

Function
REQ-010 SHALL register all merged A-channel outputs in one output slot; no combinational path from aw*/ar* inputs to A outputs.
REQ-011 SHALL define slot_free = !avalid || aready.
REQ-012 SHALL assert awready/arready only for the granted direction, and only while slot_free is high (combinational from aready allowed).
REQ-013 SHALL load the slot with the granted channel's fields on the cycle slot_free and the granted valid are both high; awrite = 1 for AW, 0 for AR.
REQ-014 SHALL clear avalid when aready is high and no new grant occurs in the same cycle.
REQ-015 SHALL hold all A outputs stable while avalid && !aready (AXI stability rule).
REQ-016 SHALL, with exactly one of awvalid/arvalid high, grant that direction.
REQ-017 SHALL keep state last_dir (1 bit, 1 = write) and batch_cnt (4 bits, saturating at BATCH_LEN).
REQ-018 SHALL, on a grant in direction d: if d == last_dir, saturating-increment batch_cnt; otherwise set last_dir = d and batch_cnt = 1.
REQ-019 SHALL, with both valids high and the feature of REQ-024 off, grant !last_dir (strict alternation).
REQ-020 SHALL accept back-to-back transfers at one per cycle when aready stays high.

Reset
REQ-021 SHALL, while rst_n is low, drive avalid = 0, awready = 0, arready = 0, awrite = 0, last_dir = 0 (read), batch_cnt = 0; aid/aaddr/alen/asize/aburst reset to 0.
REQ-022 SHALL discard any slot contents on reset assertion mid-transfer; no replay after reset.
REQ-023 SHALL produce no grant in the first cycle after rst_n deasserts unless a valid input is present.

Configuration
REQ-024 SHALL compile batching in when SAL_ARB_BATCH_EN is defined: with both valids high, grant last_dir if batch_cnt < BATCH_LEN, else grant !last_dir.
REQ-025 SHALL, without SAL_ARB_BATCH_EN, use REQ-019 alternation; batch_cnt is still maintained but unused.

Structure
REQ-026 SHALL place the direction enum (DIR_RD = 0, DIR_WR = 1) and the default BATCH_LEN constant in the shared SAL_DDR2 package.
REQ-027 SHALL be a single module with no sub-module; AXI widths come from SAL_DDR2_PARAMS.svh macros.

Verification
REQ-028 SHALL cover: AW only, id=3 addr=0x100 len=3, aready=1 -> awready=1 in the same cycle; next cycle avalid=1, awrite=1, aid=3, aaddr=0x100.
REQ-029 SHALL cover: both valids held for 6 grants, batching off, after reset -> direction order W,R,W,R,W,R.
REQ-030 SHALL cover: both valids held, SAL_ARB_BATCH_EN, BATCH_LEN=4, after reset -> R,R,R,R,W,W,W,W,R.
REQ-031 SHALL cover: aready=0 for 5 cycles with the slot full -> awready=arready=0, A outputs unchanged; aready=1 -> the next grant loads on that cycle.
REQ-032 SHALL cover: rst_n pulled low while avalid=1 && aready=0 -> avalid=0 asynchronously; after release, last_dir=R and batch_cnt=0.

Source files
------------

// File: rtl/sal_ddr2_pkg.sv
// rtl/sal_ddr2_pkg.sv - shared SAL_DDR2 types and constants
package sal_ddr2_pkg;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  localparam int ARB_BATCH_LEN = 4;

endpackage

// File: rtl/axi_a_arbiter.sv
// rtl/axi_a_arbiter.sv - merges AXI AW/AR into one registered A-channel slot
// Optional: define SAL_ARB_BATCH_EN for same-direction batching under contention.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_a_arbiter
  import sal_ddr2_pkg::*;
#(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int ADDR_LEN   = 4,
  parameter int BATCH_LEN  = ARB_BATCH_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  awvalid,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [ADDR_LEN-1:0]   awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  output logic                  awready,
  input  logic                  arvalid,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [ADDR_LEN-1:0]   arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  arready,
  output logic                  avalid,
  output logic [ID_WIDTH-1:0]   aid,
  output logic [ADDR_WIDTH-1:0] aaddr,
  output logic [ADDR_LEN-1:0]   alen,
  output logic [2:0]            asize,
  output logic [1:0]            aburst,
  output logic                  awrite,
  input  logic                  aready
);

  localparam logic [3:0] BATCH_MAX = 4'(BATCH_LEN);

  dir_e       last_dir;
  logic [3:0] batch_cnt;
  logic       slot_free;
  logic       pick_wr;
  logic       grant;
  dir_e       pick_dir;

  assign slot_free = !avalid || aready;

  always_comb begin
    pick_wr = awvalid;
    if (awvalid && arvalid) begin
`ifdef SAL_ARB_BATCH_EN
      pick_wr = (batch_cnt < BATCH_MAX) ? (last_dir == DIR_WR) : (last_dir != DIR_WR);
`else
      pick_wr = (last_dir != DIR_WR);
`endif
    end
  end

  // rst_n gating keeps the readys low while the slot is held in reset
  assign awready  = rst_n && slot_free && awvalid && pick_wr;
  assign arready  = rst_n && slot_free && arvalid && !pick_wr;
  assign grant    = awready || arready;
  assign pick_dir = pick_wr ? DIR_WR : DIR_RD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avalid    <= 1'b0;
      aid       <= '0;
      aaddr     <= '0;
      alen      <= '0;
      asize     <= '0;
      aburst    <= '0;
      awrite    <= 1'b0;
      last_dir  <= DIR_RD;
      batch_cnt <= 4'd0;
    end else if (grant) begin
      avalid <= 1'b1;
      awrite <= pick_wr;
      if (pick_wr) begin
        aid    <= awid;
        aaddr  <= awaddr;
        alen   <= awlen;
        asize  <= awsize;
        aburst <= awburst;
      end else begin
        aid    <= arid;
        aaddr  <= araddr;
        alen   <= arlen;
        asize  <= arsize;
        aburst <= arburst;
      end
      if (pick_dir == last_dir) begin
        batch_cnt <= (batch_cnt >= BATCH_MAX) ? BATCH_MAX : batch_cnt + 4'd1;
      end else begin
        last_dir  <= pick_dir;
        batch_cnt <= 4'd1;
      end
    end else if (aready) begin
      avalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_a_arbiter.sv
// tb/tb_axi_a_arbiter.sv - randomized model-checked bench for axi_a_arbiter
module tb_axi_a_arbiter;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int LW = 4;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, arvalid = 1'b0, aready = 1'b0;
  logic [IW-1:0] awid = '0, arid = '0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [LW-1:0] awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0;
  logic          awready, arready, avalid, awrite;
  logic [IW-1:0] aid;
  logic [AW-1:0] aaddr;
  logic [LW-1:0] alen;
  logic [2:0]    asize;
  logic [1:0]    aburst;

  axi_a_arbiter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .ADDR_LEN(LW), .BATCH_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .avalid(avalid), .aid(aid), .aaddr(aaddr), .alen(alen), .asize(asize),
    .aburst(aburst), .awrite(awrite), .aready(aready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the slot contents plus the history of granted directions.
  bit            m_valid, m_write;
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic [2:0]    m_size;
  logic [1:0]    m_burst;
  bit            gq[$];

  function automatic bit m_last();
    return (gq.size() == 0) ? 1'b0 : gq[gq.size()-1];
  endfunction

  function automatic int m_run();
    int r = 0;
    for (int i = gq.size() - 1; i >= 0; i--) begin
      if (gq[i] != m_last()) break;
      r++;
    end
    return r;
  endfunction

  function automatic bit m_pick_wr(input bit aw, input bit ar);
    if (!(aw && ar)) return aw;
`ifdef SAL_ARB_BATCH_EN
    return (m_run() < BL) ? m_last() : !m_last();
`else
    return !m_last();
`endif
  endfunction

  always @(negedge clk) begin
    bit free, pw, ew, er;
    if (!rst_n) begin
      gq.delete();
      m_valid = 0; m_write = 0; m_id = '0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
      chk("rst_avalid", 64'(avalid), 64'(0));
      chk("rst_awready", 64'(awready), 64'(0));
      chk("rst_arready", 64'(arready), 64'(0));
      chk("rst_awrite", 64'(awrite), 64'(0));
      chk("rst_aaddr", 64'(aaddr), 64'(0));
    end else begin
      chk("avalid", 64'(avalid), 64'(m_valid));
      chk("awrite", 64'(awrite), 64'(m_write));
      chk("aid", 64'(aid), 64'(m_id));
      chk("aaddr", 64'(aaddr), 64'(m_addr));
      chk("alen", 64'(alen), 64'(m_len));
      chk("asize", 64'(asize), 64'(m_size));
      chk("aburst", 64'(aburst), 64'(m_burst));
      free = !m_valid || aready;
      pw = m_pick_wr(awvalid, arvalid);
      ew = free && awvalid && pw;
      er = free && arvalid && !pw;
      chk("awready", 64'(awready), 64'(ew));
      chk("arready", 64'(arready), 64'(er));
      if (ew || er) begin
        m_valid = 1; m_write = ew;
        m_id    = ew ? awid : arid;
        m_addr  = ew ? awaddr : araddr;
        m_len   = ew ? awlen : arlen;
        m_size  = ew ? awsize : arsize;
        m_burst = ew ? awburst : arburst;
        gq.push_back(ew);
      end else if (aready) begin
        m_valid = 0;
      end
    end
  end

  task automatic idle_inputs();
    awvalid = 0; arvalid = 0; aready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) step();
    rst_n = 1;
  endtask

  int n_ord;
  bit ord[9];

  initial begin
    do_reset();
    chk("post_rst_avalid", 64'(avalid), 64'(0));
    chk("post_rst_awready", 64'(awready), 64'(0));

    // Single AW beat with aready high.
    awvalid = 1; awid = 4'd3; awaddr = 32'h100; awlen = 4'd3; awsize = 3'd2; awburst = 2'd1;
    aready = 1;
    #1;
    chk("aw_only_awready", 64'(awready), 64'(1));
    chk("aw_only_arready", 64'(arready), 64'(0));
    step();
    awvalid = 0;
    chk("aw_only_avalid", 64'(avalid), 64'(1));
    chk("aw_only_awrite", 64'(awrite), 64'(1));
    chk("aw_only_aid", 64'(aid), 64'(3));
    chk("aw_only_aaddr", 64'(aaddr), 64'(32'h100));
    chk("aw_only_alen", 64'(alen), 64'(3));
    step();
    chk("aw_only_drain", 64'(avalid), 64'(0));

    // Stall with a full slot.
    do_reset();
    awvalid = 1; awaddr = 32'hABC0; aready = 0;
    step();
    arvalid = 1; araddr = 32'h7770; awaddr = 32'hDEAD0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_awready", 64'(awready), 64'(0));
      chk("stall_arready", 64'(arready), 64'(0));
      chk("stall_avalid", 64'(avalid), 64'(1));
      chk("stall_aaddr", 64'(aaddr), 64'(32'hABC0));
      step();
    end
    awvalid = 0; araddr = 32'h5550; aready = 1;
    #1;
    chk("unstall_arready", 64'(arready), 64'(1));
    step();
    arvalid = 0;
    chk("unstall_awrite", 64'(awrite), 64'(0));
    chk("unstall_aaddr", 64'(aaddr), 64'(32'h5550));

    // Asynchronous reset while the slot is stalled.
    aready = 0; awvalid = 1; awaddr = 32'h900;
    step();
    awvalid = 0;
    chk("pre_arst_avalid", 64'(avalid), 64'(1));
    #2 rst_n = 0;
    #1;
    chk("arst_avalid", 64'(avalid), 64'(0));
    repeat (2) step();
    rst_n = 1;
    chk("arst_last_dir", 64'(dut.last_dir), 64'(0));
    chk("arst_batch_cnt", 64'(dut.batch_cnt), 64'(0));
    step();
    chk("arst_no_replay", 64'(avalid), 64'(0));

    // Direction order with both valids held after reset.
`ifdef SAL_ARB_BATCH_EN
    n_ord = 9;
    ord = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
    n_ord = 6;
    ord = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
`endif
    do_reset();
    awvalid = 1; arvalid = 1; aready = 1;
    awaddr = 32'h1000; araddr = 32'h2000;
    for (int i = 0; i < n_ord; i++) begin
      step();
      chk($sformatf("order_%0d", i), 64'(awrite), 64'(ord[i]));
    end
    idle_inputs();
    step();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      awvalid = 1'($urandom_range(0, 1));
      arvalid = 1'($urandom_range(0, 1));
      aready  = ($urandom_range(0, 9) < 7);
      awid = IW'($urandom); awaddr = $urandom; awlen = LW'($urandom);
      awsize = 3'($urandom); awburst = 2'($urandom);
      arid = IW'($urandom); araddr = $urandom; arlen = LW'($urandom);
      arsize = 3'($urandom); arburst = 2'($urandom);
      if (c % 700 == 350) begin
        rst_n = 0;
        step();
        rst_n = 1;
      end
      step();
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
